digit_entry: RTL and testbench
==============================

// Module: digit_entry
// PURPOSE
//  Upstream of code_checker. Debounces the digit-enter button and reads one digit per press
//  from the switches. Collects PASS_LEN digits and presents them as one packed code.
//  Holds the code under a valid/ack handshake until code_checker (via Controller) takes it.
//  Also clears partial entries on a clear press or after an idle timeout.
// PARAMETERS
//  DIGIT_W          4            bits per digit
//  PASS_LEN         4            digits per code (1..8)
//  MAX_DIGIT        9            largest legal digit; larger switch values are rejected
//  DEBOUNCE_CYCLES  500000       cycles a button must be stable (10 ms @ 50 MHz)
//  TIMEOUT_CYCLES   500000000    idle cycles before a partial entry is discarded (10 s)
// PORTS
//  clk            in   1                    system clock (CLOCK_50)
//  system_reset   in   1                    synchronous, active-high reset
//  digit_in       in   DIGIT_W              switch value (SW), asynchronous to clk
//  enter_btn      in   1                    digit-enter button, active high (~KEY), asynchronous
//  clear_btn      in   1                    clear button, active high, asynchronous
//  code_ack       in   1                    consumer has taken code_out
//  code_out       out  DIGIT_W*PASS_LEN     digit 0 (first entered) in bits [DIGIT_W-1:0]
//  code_valid     out  1                    code_out holds a complete code
//  digit_count    out  4                    digits accepted so far in the current entry
//  digit_error    out  1                    1-cycle pulse: press rejected, digit > MAX_DIGIT
//  timeout        out  1                    1-cycle pulse: partial entry discarded by the idle timer
// BEHAVIOUR
//  Reset
//   - All outputs are 0. code_out is 0. State is IDLE.
//   - Synchronizers, debounced levels and counters are cleared.
//   - Reset wins over every other event in the same cycle.
//  Input conditioning
//   - Each button passes through a 2-flop synchronizer and then a debounce counter.
//   - The debounced level changes only after the raw level has been stable for
//     DEBOUNCE_CYCLES consecutive cycles.
//   - A press event is a 1-cycle pulse on the debounced rising edge.
//   - digit_in passes through a 2-flop synchronizer. It is sampled on the cycle of the
//     enter press event.
//  FSM
//   - IDLE: digit_count = 0.
//       - Legal enter press: store the digit in slot 0, set count to 1, go to COLLECT.
//       - If PASS_LEN = 1, go to FULL instead.
//   - COLLECT
//       - Legal enter press: store the digit in slot[count] and increment count.
//         When count reaches PASS_LEN, go to FULL.
//       - Clear press: count = 0, go to IDLE.
//       - Idle timer reaches TIMEOUT_CYCLES: count = 0, pulse timeout, go to IDLE.
//       - The idle timer restarts on every accepted or rejected enter press.
//   - FULL
//       - code_valid = 1 on the cycle after the last digit is accepted.
//       - code_out is stable while code_valid = 1.
//       - Enter and clear presses are ignored. No digit_error is raised. The timer is stopped.
//       - code_ack = 1: next cycle code_valid = 0, count = 0, go to IDLE.
//       - code_out keeps its last value.
//  Rejection and event rules
//   - An enter press with digit > MAX_DIGIT pulses digit_error in the next cycle.
//     The state and count do not change.
//   - Enter and clear press in the same cycle: clear wins and the digit is discarded.
//   - code_ack while not in FULL is ignored.
//  Widths
//   - digit_count saturates at PASS_LEN.
//   - Slots beyond the current count hold stale data, and consumers must not use them
//     until code_valid = 1.
//   - Timers are sized with $clog2 of their parameter and never wrap.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50, PASS_LEN=4)
//  1. Enter 3, 1, 4, 1 with clean presses, then hold ack low 10 cycles
//     -> code_valid=1, code_out=16'h1413 (digit0 in the low nibble), output stable.
//     Then pulse code_ack -> valid=0 next cycle, count=0.
//  2. Press shorter than 4 cycles, or a 3-cycle bounce train before a stable press
//     -> exactly one digit is accepted, or none for the short press. Count is checked.
//  3. SW=4'hC, then press -> digit_error pulses once and count is unchanged.
//     Then SW=7, press -> count increments.
//  4. Two digits entered, then 50 idle cycles -> timeout pulses once and count=0.
//     Clear during COLLECT -> count=0 and no timeout pulse.
//  5. In FULL, press enter and clear, and vary SW -> code_out and count are unchanged
//     and no error is raised. Enter and clear pressed together in COLLECT -> cleared.
//  6. Assert system_reset mid-entry (count=2) and in FULL -> all outputs 0 next cycle.
//     A fresh entry after reset works.

Source files
------------

// File: rtl/digit_entry.sv
// digit_entry: debounces enter/clear buttons, collects PASS_LEN switch digits
// into one packed code and holds it under a valid/ack handshake.
module digit_entry #(
  parameter int DIGIT_W         = 4,
  parameter int PASS_LEN        = 4,
  parameter int MAX_DIGIT       = 9,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 500000000
) (
  input  logic                          clk,
  input  logic                          system_reset,
  input  logic [DIGIT_W-1:0]            digit_in,
  input  logic                          enter_btn,
  input  logic                          clear_btn,
  input  logic                          code_ack,
  output logic [DIGIT_W*PASS_LEN-1:0]   code_out,
  output logic                          code_valid,
  output logic [3:0]                    digit_count,
  output logic                          digit_error,
  output logic                          timeout
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TM_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SLOT_W = (PASS_LEN > 1) ? $clog2(PASS_LEN) : 1;
  localparam logic [DB_W-1:0]    DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0]    TM_LAST  = TM_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]         LEN_LAST = 4'(PASS_LEN - 1);
  localparam logic [DIGIT_W-1:0] MAX_D    = DIGIT_W'(MAX_DIGIT);

  typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

  // Button conditioning, index 0 = enter, 1 = clear
  logic [1:0]            w_raw;
  logic [1:0][1:0]       r_bsync;
  logic [1:0]            r_level;
  logic [1:0]            r_level_q;
  logic [1:0][DB_W-1:0]  r_dbcnt;
  logic [1:0]            w_press;

  logic [DIGIT_W-1:0]    r_dsync1;
  logic [DIGIT_W-1:0]    r_dsync2;

  state_t                          r_state;
  logic [PASS_LEN-1:0][DIGIT_W-1:0] r_code;
  logic [3:0]                      r_count;
  logic [TM_W-1:0]                 r_timer;
  logic                            r_valid;
  logic                            r_err;
  logic                            r_to;

  logic                 w_enter;
  logic                 w_clear;
  logic                 w_bad;
  logic [SLOT_W-1:0]    w_slot;

  assign w_raw = {clear_btn, enter_btn};

  // Two-flop synchronizers plus a stability counter per button; the level
  // flips only once the synchronized input has differed for DEBOUNCE_CYCLES.
  always_ff @(posedge clk) begin
    if (system_reset) begin
      r_bsync   <= '0;
      r_level   <= '0;
      r_level_q <= '0;
      r_dbcnt   <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        r_bsync[b]   <= {r_bsync[b][0], w_raw[b]};
        r_level_q[b] <= r_level[b];
        if (r_bsync[b][1] == r_level[b]) begin
          r_dbcnt[b] <= '0;
        end else if (r_dbcnt[b] == DB_LAST) begin
          r_level[b] <= r_bsync[b][1];
          r_dbcnt[b] <= '0;
        end else begin
          r_dbcnt[b] <= r_dbcnt[b] + 1'b1;
        end
      end
    end
  end

  assign w_press = r_level & ~r_level_q;

  // Switch synchronizer; value is taken on the enter press cycle
  always_ff @(posedge clk) begin
    if (system_reset) begin
      r_dsync1 <= '0;
      r_dsync2 <= '0;
    end else begin
      r_dsync1 <= digit_in;
      r_dsync2 <= r_dsync1;
    end
  end

  assign w_enter = w_press[0];
  assign w_clear = w_press[1];
  assign w_bad   = (r_dsync2 > MAX_D);
  assign w_slot  = r_count[SLOT_W-1:0];

  // Entry FSM; clear beats enter, timer runs only in COLLECT
  always_ff @(posedge clk) begin
    if (system_reset) begin
      r_state <= IDLE;
      r_code  <= '0;
      r_count <= '0;
      r_timer <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      r_to  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_timer <= '0;
          if (!w_clear && w_enter) begin
            if (w_bad) begin
              r_err <= 1'b1;
            end else begin
              r_code[0] <= r_dsync2;
              r_count   <= 4'd1;
              if (PASS_LEN == 1) begin
                r_state <= FULL;
                r_valid <= 1'b1;
              end else begin
                r_state <= COLLECT;
              end
            end
          end
        end
        COLLECT: begin
          if (w_clear) begin
            r_count <= '0;
            r_timer <= '0;
            r_state <= IDLE;
          end else if (w_enter) begin
            r_timer <= '0;
            if (w_bad) begin
              r_err <= 1'b1;
            end else begin
              r_code[w_slot] <= r_dsync2;
              r_count        <= r_count + 4'd1;
              if (r_count == LEN_LAST) begin
                r_state <= FULL;
                r_valid <= 1'b1;
              end
            end
          end else if (r_timer == TM_LAST) begin
            r_count <= '0;
            r_timer <= '0;
            r_to    <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        FULL: begin
          if (code_ack) begin
            r_valid <= 1'b0;
            r_count <= '0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign code_out    = r_code;
  assign code_valid  = r_valid;
  assign digit_count = r_count;
  assign digit_error = r_err;
  assign timeout     = r_to;

endmodule

// File: tb/tb_digit_entry.sv
// Scoreboard bench for digit_entry: stimulus pushes expected code/error/timeout
// events, a monitor pops them as the DUT raises them.
module tb_digit_entry;

  logic        clk = 1'b0;
  logic        system_reset;
  logic [3:0]  digit_in;
  logic        enter_btn;
  logic        clear_btn;
  logic        code_ack;
  logic [15:0] code_out;
  logic        code_valid;
  logic [3:0]  digit_count;
  logic        digit_error;
  logic        timeout;

  typedef struct {
    int          kind;   // 0 code, 1 digit_error, 2 timeout
    logic [15:0] val;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  digit_entry #(
    .DIGIT_W(4), .PASS_LEN(4), .MAX_DIGIT(9),
    .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .system_reset(system_reset), .digit_in(digit_in),
    .enter_btn(enter_btn), .clear_btn(clear_btn), .code_ack(code_ack),
    .code_out(code_out), .code_valid(code_valid), .digit_count(digit_count),
    .digit_error(digit_error), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [15:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] d, input int hold);
    @(negedge clk);
    digit_in  = d;
    enter_btn = 1'b1;
    cyc(hold);
    enter_btn = 1'b0;
    cyc(12);
  endtask

  task automatic press_clear(input int hold);
    @(negedge clk);
    clear_btn = 1'b1;
    cyc(hold);
    clear_btn = 1'b0;
    cyc(12);
  endtask

  task automatic press_both(input logic [3:0] d);
    @(negedge clk);
    digit_in  = d;
    enter_btn = 1'b1;
    clear_btn = 1'b1;
    cyc(6);
    enter_btn = 1'b0;
    clear_btn = 1'b0;
    cyc(12);
  endtask

  task automatic ack();
    @(negedge clk);
    code_ack = 1'b1;
    @(negedge clk);
    code_ack = 1'b0;
    check("ack_valid", {31'd0, code_valid}, 32'd0);
    check("ack_count", {28'd0, digit_count}, 32'd0);
  endtask

  task automatic check_zero(input string name);
    check({name, "_code"},  {16'd0, code_out}, 32'd0);
    check({name, "_valid"}, {31'd0, code_valid}, 32'd0);
    check({name, "_count"}, {28'd0, digit_count}, 32'd0);
    check({name, "_err"},   {31'd0, digit_error}, 32'd0);
    check({name, "_to"},    {31'd0, timeout}, 32'd0);
  endtask

  // Monitor: every output event must match the head of the expected queue
  initial begin
    logic prev_v;
    ev_t  e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        logic hit;
        logic [15:0] v;
        hit = (k == 0) ? (code_valid && !prev_v) : (k == 1) ? digit_error : timeout;
        v   = (k == 0) ? code_out : 16'd0;
        if (hit) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d val %0h expected none", k, v);
          end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val !== v) begin
              n_fail++;
              $display("FAIL event: got kind %0d val %0h expected kind %0d val %0h",
                       k, v, e.kind, e.val);
            end
          end
        end
      end
      prev_v = code_valid;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    system_reset = 1'b1;
    digit_in  = 4'd0;
    enter_btn = 1'b0;
    clear_btn = 1'b0;
    code_ack  = 1'b0;
    cyc(3);
    check_zero("reset");
    system_reset = 1'b0;
    cyc(2);

    // 1: 3,1,4,1 -> 0x1413, held stable while ack low
    press(4'd3, 6);
    press(4'd1, 6);
    press(4'd4, 6);
    check("t1_count3", {28'd0, digit_count}, 32'd3);
    push(0, 16'h1413);
    press(4'd1, 6);
    for (int i = 0; i < 10; i++) begin
      check("t1_stable_code", {16'd0, code_out}, 32'h1413);
      check("t1_stable_valid", {31'd0, code_valid}, 32'd1);
      cyc(1);
    end
    check("t1_count4", {28'd0, digit_count}, 32'd4);
    ack();

    // 2: short press ignored, bounce train then stable press counts once
    press(4'd5, 3);
    check("t2_short", {28'd0, digit_count}, 32'd0);
    @(negedge clk);
    digit_in = 4'd6;
    for (int i = 0; i < 3; i++) begin
      enter_btn = 1'b1;
      cyc(1);
      enter_btn = 1'b0;
      cyc(1);
    end
    press(4'd6, 6);
    check("t2_bounce", {28'd0, digit_count}, 32'd1);
    press(4'd6, 2);
    check("t2_short2", {28'd0, digit_count}, 32'd1);

    // 3: illegal digit rejected, then legal digit accepted
    push(1, 16'd0);
    press(4'hC, 6);
    check("t3_reject", {28'd0, digit_count}, 32'd1);
    press(4'd7, 6);
    check("t3_accept", {28'd0, digit_count}, 32'd2);

    // 4: idle timeout clears, clear press clears without timeout
    push(2, 16'd0);
    cyc(60);
    check("t4_timeout", {28'd0, digit_count}, 32'd0);
    press(4'd5, 6);
    check("t4_one", {28'd0, digit_count}, 32'd1);
    press_clear(6);
    check("t4_clear", {28'd0, digit_count}, 32'd0);
    cyc(60);
    check("t4_idle", {28'd0, digit_count}, 32'd0);

    // 5: presses ignored in FULL; enter+clear together clears
    press(4'd9, 6);
    press(4'd8, 6);
    press(4'd7, 6);
    push(0, 16'h6789);
    press(4'd6, 6);
    press(4'd2, 6);
    press_clear(6);
    press(4'hF, 6);
    check("t5_code", {16'd0, code_out}, 32'h6789);
    check("t5_count", {28'd0, digit_count}, 32'd4);
    check("t5_valid", {31'd0, code_valid}, 32'd1);
    ack();
    check("t5_keep", {16'd0, code_out}, 32'h6789);
    press(4'd1, 6);
    check("t5_one", {28'd0, digit_count}, 32'd1);
    press_both(4'd2);
    check("t5_both", {28'd0, digit_count}, 32'd0);

    // 6: reset mid-entry and in FULL, then a fresh entry
    press(4'd2, 6);
    press(4'd3, 6);
    check("t6_count2", {28'd0, digit_count}, 32'd2);
    @(negedge clk);
    system_reset = 1'b1;
    @(negedge clk);
    check_zero("t6_rst_mid");
    system_reset = 1'b0;
    press(4'd1, 6);
    press(4'd2, 6);
    press(4'd3, 6);
    push(0, 16'h4321);
    press(4'd4, 6);
    check("t6_full", {31'd0, code_valid}, 32'd1);
    @(negedge clk);
    system_reset = 1'b1;
    @(negedge clk);
    check_zero("t6_rst_full");
    system_reset = 1'b0;
    press(4'd5, 6);
    press(4'd0, 6);
    press(4'd0, 6);
    push(0, 16'h9005);
    press(4'd9, 6);
    check("t6_fresh", {16'd0, code_out}, 32'h9005);
    ack();

    cyc(5);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
